// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-bundle field layout and flag payload type for the ID/EX stage.
package id_ex_stage_pkg;

    localparam int unsigned REG_DATA_WIDTH = 64;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned CTRL_W         = 8;

    // Layout of the opaque control bundle as EX decodes it
    localparam int unsigned CTRL_ALU_OP_LSB = 0;
    localparam int unsigned CTRL_ALU_OP_W   = 4;
    localparam int unsigned CTRL_BR_OP_LSB  = 4;
    localparam int unsigned CTRL_BR_OP_W    = 3;
    localparam int unsigned CTRL_JUMP_BIT   = 7;

    localparam int unsigned PERF_CNT_W = 32;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ex_flags_t;

    localparam ex_flags_t FLAGS_NONE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection and ID stall generation.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_WIDTH
) (
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_rd_addr,
    input  logic              id_valid,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              luh_c,
    output logic              id_stall
);

    // A load targeting x0 produces nothing to wait for
    always_comb begin
        luh_c = 1'b0;
        if (ex_valid && ex_mem_read && (ex_rd_addr != '0) && id_valid) begin
            luh_c = (id_use_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                    (id_use_rs2 && (id_rs2_addr == ex_rd_addr));
        end
    end

    // Redirect overrides every stall reason; nothing stalls while reset is held
    assign id_stall = reset && (luh_c || ex_hold) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, hold, flush and writeback snoop.
// Optional performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::ex_flags_t;
    import id_ex_stage_pkg::FLAGS_NONE;
    import id_ex_stage_pkg::PERF_CNT_W;
#(
    parameter int unsigned DATA_W = id_ex_stage_pkg::REG_DATA_WIDTH,
    parameter int unsigned ADDR_W = id_ex_stage_pkg::REG_ADDR_WIDTH,
    parameter int unsigned CTRL_W = id_ex_stage_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] id_rs1_addr,
    input  logic [ADDR_W-1:0] id_rs2_addr,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [ADDR_W-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rs1_addr,
    output logic [ADDR_W-1:0] ex_rs2_addr,
    output logic [ADDR_W-1:0] ex_rd_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              id_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_bubble_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

    ex_flags_t flags_q;
    ex_flags_t id_flags_c;
    logic      luh_c;
    logic      snoop_rs1_c;
    logic      snoop_rs2_c;

    id_ex_stage_hazard_detect #(
        .ADDR_W (ADDR_W)
    ) u_hazard_detect (
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_mem_read (flags_q.mem_read),
        .ex_rd_addr  (ex_rd_addr),
        .id_valid    (id_valid),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .ex_hold     (ex_hold),
        .flush       (flush),
        .luh_c       (luh_c),
        .id_stall    (id_stall)
    );

    // An empty ID slot must never carry side-effect flags into EX
    always_comb begin
        id_flags_c = FLAGS_NONE;
        if (id_valid) begin
            id_flags_c.reg_write = id_reg_write;
            id_flags_c.mem_read  = id_mem_read;
            id_flags_c.mem_write = id_mem_write;
        end
    end

    assign snoop_rs1_c = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs1_addr);
    assign snoop_rs2_c = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == ex_rs2_addr);

    // Update priority: flush, hold (with snoop), load-use bubble, load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_ctrl     <= '0;
            flags_q     <= FLAGS_NONE;
        end else if (flush) begin
            ex_valid <= 1'b0;
            flags_q  <= FLAGS_NONE;
        end else if (ex_hold) begin
            if (snoop_rs1_c) ex_rs1_data <= wb_data;
            if (snoop_rs2_c) ex_rs2_data <= wb_data;
        end else if (luh_c) begin
            ex_valid <= 1'b0;
            flags_q  <= FLAGS_NONE;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1_addr <= id_rs1_addr;
            ex_rs2_addr <= id_rs2_addr;
            ex_rd_addr  <= id_rd_addr;
            ex_ctrl     <= id_ctrl;
            flags_q     <= id_flags_c;
        end
    end

    assign ex_reg_write = flags_q.reg_write;
    assign ex_mem_read  = flags_q.mem_read;
    assign ex_mem_write = flags_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
    // Free-running event counters, wrapping naturally at their width
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (flush) perf_flush_cnt <= perf_flush_cnt + PERF_CNT_W'(1);
            if (!flush && !ex_hold && luh_c) perf_bubble_cnt <= perf_bubble_cnt + PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, corner sequences, random vs. reference model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic        use1;
        logic        use2;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [7:0]  ctrl;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        hold;
        logic        flush;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [63:0] wb_data;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [7:0]  ctrl;
        logic        rw;
        logic        mr;
        logic        mw;
    } slot_t;

    typedef struct {
        in_t         in;
        logic        stall;
        logic        valid;
        logic        chk_data;
        logic [63:0] pc;
        logic [63:0] rs1d;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [7:0]  id_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        ex_hold, flush, wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [7:0]  ex_ctrl;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        id_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    slot_t       m;
    logic        m_known;
    logic [31:0] exp_bubbles;
    logic [31:0] exp_flushes;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_rd_addr   (id_rd_addr),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .ex_hold      (ex_hold),
        .flush        (flush),
        .wb_reg_write (wb_reg_write),
        .wb_rd_addr   (wb_rd_addr),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rs1_addr  (ex_rs1_addr),
        .ex_rs2_addr  (ex_rs2_addr),
        .ex_rd_addr   (ex_rd_addr),
        .ex_ctrl      (ex_ctrl),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .id_stall     (id_stall)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic vld, input logic [63:0] pc,
                               input logic [4:0] r1, input logic u1, input logic [63:0] d1,
                               input logic [4:0] r2, input logic u2, input logic [63:0] d2,
                               input logic [4:0] rd, input logic [63:0] imm,
                               input logic rw, input logic mr, input logic mw);
        in_t v = '0;
        v.valid = vld; v.pc = pc;
        v.rs1a = r1; v.use1 = u1; v.rs1d = d1;
        v.rs2a = r2; v.use2 = u2; v.rs2d = d2;
        v.rd = rd; v.imm = imm; v.ctrl = pc[7:0];
        v.rw = rw; v.mr = mr; v.mw = mw;
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.valid   = ($urandom_range(0, 3) != 0);
        v.pc      = {$urandom, $urandom};
        v.rs1a    = 5'($urandom_range(0, 3));
        v.rs2a    = 5'($urandom_range(0, 3));
        v.use1    = 1'($urandom_range(0, 1));
        v.use2    = 1'($urandom_range(0, 1));
        v.rs1d    = {$urandom, $urandom};
        v.rs2d    = {$urandom, $urandom};
        v.rd      = 5'($urandom_range(0, 3));
        v.imm     = {$urandom, $urandom};
        v.ctrl    = 8'($urandom);
        v.rw      = 1'($urandom_range(0, 1));
        v.mr      = 1'($urandom_range(0, 1));
        v.mw      = 1'($urandom_range(0, 1));
        v.hold    = ($urandom_range(0, 3) == 0);
        v.flush   = ($urandom_range(0, 7) == 0);
        v.wb_we   = 1'($urandom_range(0, 1));
        v.wb_rd   = 5'($urandom_range(0, 3));
        v.wb_data = {$urandom, $urandom};
        return v;
    endfunction

    task automatic apply(input in_t v);
        id_valid = v.valid; id_pc = v.pc;
        id_rs1_addr = v.rs1a; id_rs2_addr = v.rs2a;
        id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        id_rs1_data = v.rs1d; id_rs2_data = v.rs2d;
        id_rd_addr = v.rd; id_imm = v.imm; id_ctrl = v.ctrl;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw;
        ex_hold = v.hold; flush = v.flush;
        wb_reg_write = v.wb_we; wb_rd_addr = v.wb_rd; wb_data = v.wb_data;
    endtask

    // The instruction in ID needs a value a load in EX has not produced yet
    function automatic logic m_luh(input slot_t s, input in_t v);
        logic needs;
        needs = (v.use1 && v.rs1a == s.rd) || (v.use2 && v.rs2a == s.rd);
        return s.valid && s.mr && (s.rd != 5'd0) && v.valid && needs;
    endfunction

    function automatic slot_t m_next(input slot_t s, input in_t v);
        slot_t n = s;
        if (v.flush) begin
            n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
        end else if (v.hold) begin
            if (v.wb_we && v.wb_rd != 5'd0 && v.wb_rd == s.rs1a) n.rs1d = v.wb_data;
            if (v.wb_we && v.wb_rd != 5'd0 && v.wb_rd == s.rs2a) n.rs2d = v.wb_data;
        end else if (m_luh(s, v)) begin
            n.valid = 1'b0; n.rw = 1'b0; n.mr = 1'b0; n.mw = 1'b0;
        end else begin
            n.valid = v.valid; n.pc = v.pc; n.rs1a = v.rs1a; n.rs2a = v.rs2a; n.rd = v.rd;
            n.rs1d = v.rs1d; n.rs2d = v.rs2d; n.imm = v.imm; n.ctrl = v.ctrl;
            n.rw = v.valid & v.rw; n.mr = v.valid & v.mr; n.mw = v.valid & v.mw;
        end
        return n;
    endfunction

    task automatic model_adv(input in_t v);
        logic bubble;
        bubble = !v.flush && !v.hold && m_luh(m, v);
        if (bubble) exp_bubbles++;
        if (v.flush) exp_flushes++;
        if (!v.flush && !v.hold) m_known = !bubble;
        m = m_next(m, v);
    endtask

    task automatic check_slot();
        check("ex_valid", 64'(ex_valid), 64'(m.valid));
        check("ex_reg_write", 64'(ex_reg_write), 64'(m.rw));
        check("ex_mem_read", 64'(ex_mem_read), 64'(m.mr));
        check("ex_mem_write", 64'(ex_mem_write), 64'(m.mw));
        if (m_known) begin
            check("ex_pc", ex_pc, m.pc);
            check("ex_rs1_data", ex_rs1_data, m.rs1d);
            check("ex_rs2_data", ex_rs2_data, m.rs2d);
            check("ex_imm", ex_imm, m.imm);
            check("ex_rs1_addr", 64'(ex_rs1_addr), 64'(m.rs1a));
            check("ex_rs2_addr", 64'(ex_rs2_addr), 64'(m.rs2a));
            check("ex_rd_addr", 64'(ex_rd_addr), 64'(m.rd));
            check("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
        end
`ifdef ID_EX_PERF_CNT_EN
        check("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(exp_bubbles));
        check("perf_flush_cnt", 64'(perf_flush_cnt), 64'(exp_flushes));
`endif
    endtask

    // Called at posedge+1: drive, check stall, clock, check registered slot
    task automatic step(input in_t v);
        logic exp_stall;
        apply(v);
        #1;
        exp_stall = !v.flush && (v.hold || m_luh(m, v));
        check("id_stall", 64'(id_stall), 64'(exp_stall));
        @(posedge clk);
        model_adv(v);
        #1;
        check_slot();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(ex_valid), 64'd0);
        check({tag, "_data"}, ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 64'd0);
        check({tag, "_addr"}, 64'({ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl}), 64'd0);
        check({tag, "_flags"}, 64'({ex_reg_write, ex_mem_read, ex_mem_write}), 64'd0);
        check({tag, "_stall"}, 64'(id_stall), 64'd0);
`ifdef ID_EX_PERF_CNT_EN
        check({tag, "_perf"}, 64'({perf_bubble_cnt, perf_flush_cnt}), 64'd0);
`endif
    endtask

    initial begin
        vec_t tbl[7];
        in_t  v;
        in_t  z = '0;

        tbl[0] = '{mk(1'b1, 64'h100, 5'd1, 1'b1, 64'd5, 5'd2, 1'b1, 64'd0, 5'd3, -64'd4, 1'b1, 1'b1, 1'b0),
                   1'b0, 1'b1, 1'b1, 64'h100, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 5'd3, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{mk(1'b1, 64'h104, 5'd4, 1'b1, 64'd9, 5'd3, 1'b1, 64'd0, 5'd5, 64'd0, 1'b1, 1'b0, 1'b0),
                   1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{mk(1'b1, 64'h104, 5'd4, 1'b1, 64'd9, 5'd3, 1'b1, 64'd0, 5'd5, 64'd0, 1'b1, 1'b0, 1'b0),
                   1'b0, 1'b1, 1'b1, 64'h104, 64'd9, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{mk(1'b1, 64'h108, 5'd0, 1'b0, 64'd7, 5'd0, 1'b0, 64'd0, 5'd0, 64'd8, 1'b1, 1'b1, 1'b0),
                   1'b0, 1'b1, 1'b1, 64'h108, 64'd7, 64'd8, 5'd0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{mk(1'b1, 64'h10C, 5'd0, 1'b1, 64'd0, 5'd0, 1'b1, 64'd0, 5'd3, 64'd16, 1'b1, 1'b1, 1'b0),
                   1'b0, 1'b1, 1'b1, 64'h10C, 64'd0, 64'd16, 5'd3, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{mk(1'b1, 64'h110, 5'd3, 1'b0, 64'h11, 5'd3, 1'b0, 64'd0, 5'd6, 64'd1, 1'b1, 1'b0, 1'b0),
                   1'b0, 1'b1, 1'b1, 64'h110, 64'h11, 64'd1, 5'd6, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{mk(1'b0, 64'h114, 5'd3, 1'b1, 64'h22, 5'd0, 1'b0, 64'd0, 5'd7, 64'd2, 1'b1, 1'b1, 1'b1),
                   1'b0, 1'b0, 1'b1, 64'h114, 64'h22, 64'd2, 5'd7, 1'b0, 1'b0, 1'b0};

        // Reset with hold asserted: stall must stay low
        reset = 1'b0;
        v = z; v.hold = 1'b1;
        apply(v);
        #12;
        check_all_zero("reset");
        m = '0; m_known = 1'b1; exp_bubbles = '0; exp_flushes = '0;
        apply(z);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: normal flow, load-use bubble, x0 and unused sources
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].in);
            #1;
            check($sformatf("tbl%0d_stall", i), 64'(id_stall), 64'(tbl[i].stall));
            @(posedge clk);
            model_adv(tbl[i].in);
            #1;
            check($sformatf("tbl%0d_valid", i), 64'(ex_valid), 64'(tbl[i].valid));
            check($sformatf("tbl%0d_flags", i), 64'({ex_reg_write, ex_mem_read, ex_mem_write}),
                  64'({tbl[i].rw, tbl[i].mr, tbl[i].mw}));
            if (tbl[i].chk_data) begin
                check($sformatf("tbl%0d_pc", i), ex_pc, tbl[i].pc);
                check($sformatf("tbl%0d_rs1_data", i), ex_rs1_data, tbl[i].rs1d);
                check($sformatf("tbl%0d_imm", i), ex_imm, tbl[i].imm);
                check($sformatf("tbl%0d_rd", i), 64'(ex_rd_addr), 64'(tbl[i].rd));
            end
        end

        // Hold with writeback snoop into rs1
        v = mk(1'b1, 64'h200, 5'd7, 1'b1, 64'd1, 5'd8, 1'b1, 64'd2, 5'd9, 64'd3, 1'b1, 1'b0, 1'b0);
        v.ctrl = 8'hA5;
        step(v);
        v = mk(1'b1, 64'h204, 5'd1, 1'b1, 64'd0, 5'd1, 1'b1, 64'd0, 5'd2, 64'd0, 1'b1, 1'b0, 1'b0);
        v.hold = 1'b1; v.wb_we = 1'b1; v.wb_rd = 5'd7; v.wb_data = 64'h55;
        apply(v);
        #1;
        check("snoop_stall", 64'(id_stall), 64'd1);
        @(posedge clk);
        model_adv(v);
        #1;
        check("snoop_rs1_data", ex_rs1_data, 64'h55);
        check("snoop_rs2_data", ex_rs2_data, 64'd2);
        check("snoop_pc", ex_pc, 64'h200);
        check("snoop_ctrl_rd", 64'({ex_ctrl, ex_rd_addr, ex_rs1_addr}), 64'({8'hA5, 5'd9, 5'd7}));
        check("snoop_valid", 64'(ex_valid), 64'd1);
        v.wb_we = 1'b0; v.wb_data = 64'h77;
        step(v);
        check("snoop_no_we", ex_rs1_data, 64'h55);
        v.hold = 1'b0;
        step(v);

        // Flush beats hold and load-use together
        step(mk(1'b1, 64'h240, 5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0, 5'd3, 64'd0, 1'b1, 1'b1, 1'b0));
        v = mk(1'b1, 64'h244, 5'd3, 1'b1, 64'd0, 5'd0, 1'b0, 64'd0, 5'd4, 64'd0, 1'b1, 1'b0, 1'b0);
        v.hold = 1'b1; v.flush = 1'b1;
        apply(v);
        #1;
        check("flush_stall", 64'(id_stall), 64'd0);
        @(posedge clk);
        model_adv(v);
        #1;
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_flags", 64'({ex_reg_write, ex_mem_read, ex_mem_write}), 64'd0);
        v.hold = 1'b0; v.flush = 1'b0;
        step(v);

        // Asynchronous reset between edges while a snoop is pending
        step(mk(1'b1, 64'h300, 5'd5, 1'b1, 64'hABC, 5'd6, 1'b1, 64'hDEF, 5'd7, 64'd1, 1'b1, 1'b0, 1'b0));
        v.hold = 1'b1; v.wb_we = 1'b1; v.wb_rd = 5'd5; v.wb_data = 64'h1234;
        apply(v);
        #3;
        reset = 1'b0;
        #2;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check("reset_no_snoop", ex_rs1_data, 64'd0);
        #2;
        apply(z);
        reset = 1'b1;
        m = '0; m_known = 1'b1; exp_bubbles = '0; exp_flushes = '0;
        @(posedge clk);
        model_adv(z);
        #1;
        check_slot();

        // Random traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            step(rand_in());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
